// File: rtl/instr_fetch_queue_pkg.sv
// Shared processor definitions used by the fetch front end.
package instr_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Prefetch queue storage: power-of-two ring with flush and same-cycle push/pop when full.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // When full, a push lands in the slot being popped; the read is combinational so nothing is lost.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: credit-limited in-order memory requests feeding a decode queue,
// with redirect flush and drain of responses belonging to the abandoned path.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding, outstanding_nxt, q_count;
  logic          req_fire, rsp_take, push, pop, q_full, q_empty;
  fetch_entry_t  q_wdata, q_rdata, hold;

  // Credit: registered occupancy plus in-flight requests, no same-cycle pop bypass.
  assign imem_req_valid  = (state == FETCH) && !q_full &&
                           (({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign imem_req_addr   = imem_req_valid ? fetch_pc : '0;
  assign req_fire        = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are strays from before a reset.
  assign rsp_take        = imem_rsp_valid && (outstanding != '0);
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

  assign push = rsp_take && (state == FETCH) && !redirect_valid;
  assign pop  = dec_valid && dec_ready;

  // In FETCH all in-flight requests are sequential, so the oldest sits outstanding words behind fetch_pc.
  assign q_wdata.pc    = fetch_pc - (32'(outstanding) << 2);
  assign q_wdata.instr = imem_rsp_data;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign dec_valid = !q_empty;
  assign dec_pc    = q_empty ? hold.pc    : q_rdata.pc;
  assign dec_instr = q_empty ? hold.instr : q_rdata.instr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (redirect_valid && (outstanding_nxt != '0)) state_nxt = DRAIN;
      DRAIN:   if (!redirect_valid && (outstanding == '0)) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      hold        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      if (redirect_valid)  fetch_pc <= redirect_pc & ~32'h3;
      else if (req_fire)   fetch_pc <= fetch_pc + 32'd4;
      if (!q_empty)        hold     <= q_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a stream-level reference model.
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int unsigned vec_cnt = 0, err_cnt = 0;
  mreq_t       memq[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_req, exp_dec, last_pc, last_ins, first_tgt, force_tgt, redir_tgt;
  logic        s_rv, s_dv, want_first, force_redir, redir_on_dec, hit, spurious;
  logic [31:0] s_addr, s_pc, s_ins;
  int          cyc = 0, cyc_rel = 0, last_due = 0, first_dec = -1, dec_cnt = 0;
  int          p_ready = 100, p_dec = 100, p_redir = 0, lat_min = 1, lat_max = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, a[31:16] ^ 16'hc001} ^ 32'h0000_0013;
  endfunction

  function automatic void model_reset();
    exp_req = RESET_PC; exp_dec = RESET_PC;
    memq.delete(); req_log.delete();
    last_due = cyc; want_first = 1'b1; first_tgt = RESET_PC;
    last_pc = '0; last_ins = '0; first_dec = -1; cyc_rel = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0; imem_req_ready = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One clock: sample registered outputs, drive inputs, then advance the reference model.
  task automatic step();
    logic redir;
    int   lat, due;
    @(negedge clock); #1;
    cyc++; cyc_rel++;
    s_rv = imem_req_valid; s_addr = imem_req_addr;
    s_dv = dec_valid; s_pc = dec_pc; s_ins = dec_instr;

    imem_req_ready = ($urandom_range(99) < p_ready);
    dec_ready      = ($urandom_range(99) < p_dec);
    redir = 1'b0; redir_tgt = $urandom();
    if (force_redir) begin
      redir = 1'b1; redir_tgt = force_tgt; force_redir = 1'b0;
    end else if (redir_on_dec && s_dv && memq.size() > 0) begin
      redir = 1'b1; dec_ready = 1'b1; redir_tgt = 32'h0000_2000; redir_on_dec = 1'b0; hit = 1'b1;
    end else if ($urandom_range(999) < p_redir) begin
      redir = 1'b1;
      if ($urandom_range(3) == 0) redir_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    end
    redirect_valid = redir;
    redirect_pc    = redir_tgt;

    imem_rsp_data = $urandom();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = spurious && (memq.size() == 0);
    end
    spurious = 1'b0;

    if (s_dv) begin
      chk("dec_pc", s_pc, exp_dec);
      chk("dec_instr", s_ins, mem_word(exp_dec));
      last_pc = s_pc; last_ins = s_ins;
      if (first_dec < 0) first_dec = cyc_rel;
    end else begin
      chk("hold_pc", s_pc, last_pc);
      chk("hold_instr", s_ins, last_ins);
    end
    if (s_rv && imem_req_ready) begin
      chk("req_addr", s_addr, exp_req);
      if (want_first) chk("first_req", s_addr, first_tgt);
      want_first = 1'b0;
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      memq.push_back('{addr: s_addr, due: due});
      req_log.push_back(s_addr);
      chk("credit", 32'(memq.size() <= DEPTH), 32'd1);
      exp_req = exp_req + 32'd4;
    end
    if (s_dv && dec_ready) begin
      exp_dec = exp_dec + 32'd4;
      dec_cnt++;
    end
    if (redir) begin
      exp_req = redir_tgt & ~32'h3; exp_dec = exp_req;
      want_first = 1'b1; first_tgt = exp_req;
      req_log.delete();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    force_redir = 1'b0; redir_on_dec = 1'b0; hit = 1'b0; spurious = 1'b0;
    model_reset();
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Streaming from reset, single-cycle memory.
    run(12);
    chk("first_dec_lat", 32'(first_dec >= 1 && first_dec <= 3), 32'd1);
    chk("stream_reqs", req_log[0], 32'd0);
    chk("stream_reqs2", req_log[2], 32'd8);

    // Decode stalled: credit limits requests to DEPTH.
    do_reset(); p_dec = 0;
    run(20);
    chk("credit_reqs", 32'(req_log.size()), 32'(DEPTH));
    chk("req_stalled", 32'(s_rv), 32'd0);
    req_log.delete();
    p_dec = 100; run(1); p_dec = 0;
    run(10);
    chk("one_more_req", 32'(req_log.size()), 32'd1);

    // Redirect with two responses in flight at latency 3.
    do_reset(); p_dec = 100; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) step();
    chk("two_outstanding", 32'(memq.size()), 32'd2);
    force_redir = 1'b1; force_tgt = 32'h0000_0102;
    run(30);
    chk("redir_first", req_log[0], 32'h0000_0100);

    // Redirect to the top of the address space wraps.
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC; lat_min = 1; lat_max = 1;
    run(20);
    chk("wrap_cnt", 32'(req_log.size() >= 2), 32'd1);
    chk("wrap0", req_log[0], 32'hFFFF_FFFC);
    chk("wrap1", req_log[1], 32'h0000_0000);

    // Redirect with a same-cycle decode, then a second redirect while draining.
    do_reset(); lat_min = 3; lat_max = 3; redir_on_dec = 1'b1; hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) step();
    chk("redir_dec_hit", 32'(hit), 32'd1);
    force_redir = 1'b1; force_tgt = 32'h0000_3000;
    run(30);
    chk("second_target", req_log[0], 32'h0000_3000);

    // Asynchronous reset with a full queue, then a stray response.
    do_reset(); p_dec = 0; lat_min = 1; lat_max = 1;
    run(20);
    chk("full_dec_valid", 32'(dec_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_dec_valid", 32'(dec_valid), 32'd0);
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_dec_pc", dec_pc, 32'd0);
    model_reset();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    spurious = 1'b1; p_dec = 100;
    run(10);
    chk("post_rst_req", req_log[0], RESET_PC);

    // Random traffic.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      p_ready = $urandom_range(100, 30);
      p_dec   = $urandom_range(100, 20);
      p_redir = $urandom_range(40, 0);
      lat_min = 1; lat_max = $urandom_range(4, 1);
      run(200);
    end

    // Quiet traffic: the queue must keep delivering.
    p_redir = 0; p_ready = 100; p_dec = 100; dec_cnt = 0;
    run(60);
    chk("liveness", 32'(dec_cnt > 20), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
